// File: rtl/tl_a_channel_queue.sv
// Registered FIFO for a TileLink-style A channel. It decouples producer timing from the consumer.
// It also offers a pipe mode (enqueue while full and draining) and a flow mode (bypass when empty).
module tl_a_channel_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PIPE  = 0,
  parameter int unsigned FLOW  = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [77:0]                      in_bits,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [77:0]                      out_bits,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned BEAT_W = 78;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [BEAT_W-1:0] ram_q [DEPTH];
  logic [PTR_W-1:0]  enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0]  deq_ptr_q, deq_ptr_d;
  logic              maybe_full_q, maybe_full_d;

  logic              ptr_match, empty, full;
  logic              do_enq, do_deq, bypass, wr_en;
  logic [CNT_W:0]    diff;

  // Pointers wrap explicitly at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    ptr_match    = (enq_ptr_q == deq_ptr_q);
    empty        = ptr_match & ~maybe_full_q;
    full         = ptr_match & maybe_full_q;
    in_ready     = reset | ~full | ((PIPE != 0) & out_ready);
    out_valid    = ~reset & (~empty | ((FLOW != 0) & in_valid));
    out_bits     = ((FLOW != 0) && empty) ? in_bits : ram_q[deq_ptr_q];
    do_enq       = in_valid & in_ready;
    do_deq       = out_valid & out_ready;
    // A flow-through beat fires on both sides but never touches storage.
    bypass       = (FLOW != 0) & empty & do_deq;
    wr_en        = do_enq & ~bypass;

    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (wr_en)              enq_ptr_d    = ptr_inc(enq_ptr_q);
    if (do_deq && !bypass)  deq_ptr_d    = ptr_inc(deq_ptr_q);
    if (do_enq != do_deq)   maybe_full_d = do_enq;

    diff = '0;
    if (enq_ptr_q >= deq_ptr_q) begin
      diff = (CNT_W+1)'(enq_ptr_q) - (CNT_W+1)'(deq_ptr_q);
    end else begin
      diff = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(enq_ptr_q) - (CNT_W+1)'(deq_ptr_q);
    end
    if (reset)     count = '0;
    else if (full) count = CNT_W'(DEPTH);
    else           count = CNT_W'(diff);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_en) ram_q[enq_ptr_q] <= in_bits;
  end

`ifndef SYNTHESIS
  a_in_stable: assert property (@(posedge clock) disable iff (reset)
    (in_valid && !in_ready) |=> $stable(in_bits));

  if (FLOW == 0) begin : g_out_hold
    a_out_hold: assert property (@(posedge clock) disable iff (reset)
      (out_valid && !out_ready) |=> out_valid);
  end
`endif

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// Directed plus randomized bench for tl_a_channel_queue.
// Four configurations are instantiated and checked against a queue-based reference model.
module tb_tl_a_channel_queue;

  logic clock;
  logic reset;

  logic [3:0]       iv;
  logic [3:0]       ordy;
  logic [3:0][77:0] ib;
  wire  [3:0]       ir;
  wire  [3:0]       ov;
  wire  [3:0][77:0] ob;
  wire  [3:0][1:0]  cnt;
  wire  [0:0]       cnt_d1;

  int vectors = 0;
  int miscompares = 0;
  logic [77:0] mq [$];

  // k=0: DEPTH2, k=1: DEPTH3, k=2: DEPTH1 PIPE, k=3: DEPTH2 FLOW
  tl_a_channel_queue #(.DEPTH(2), .PIPE(0), .FLOW(0)) u_d2 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_bits(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bits(ob[0]), .count(cnt[0]));
  tl_a_channel_queue #(.DEPTH(3), .PIPE(0), .FLOW(0)) u_d3 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_bits(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bits(ob[1]), .count(cnt[1]));
  tl_a_channel_queue #(.DEPTH(1), .PIPE(1), .FLOW(0)) u_pipe (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_bits(ib[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_bits(ob[2]), .count(cnt_d1));
  tl_a_channel_queue #(.DEPTH(2), .PIPE(0), .FLOW(1)) u_flow (
    .clock(clock), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .in_bits(ib[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_bits(ob[3]), .count(cnt[3]));

  assign cnt[2] = {1'b0, cnt_d1};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dep_of(input int k);
    case (k)
      1: return 3;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [77:0] mk_beat(input logic [2:0] op, input logic [6:0] src,
                                           input logic [24:0] addr, input logic [31:0] data,
                                           input logic corrupt);
    logic [2:0] prm;
    logic [2:0] sz;
    logic [3:0] msk;
    prm = 3'($urandom_range(7));
    sz  = 3'($urandom_range(7));
    msk = 4'($urandom_range(15));
    return {op, prm, sz, src, addr, msk, data, corrupt};
  endfunction

  function automatic logic [77:0] gen(input int i);
    return mk_beat(3'($urandom_range(7)), 7'(i), 25'(4 * i), 32'($urandom), i == 7);
  endfunction

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance k: drive, predict, check mid-cycle, advance the model.
  task automatic step(input int k, input logic v, input logic [77:0] b, input logic r,
                      output logic acc);
    int len;
    logic exp_ir, exp_ov, deq, byp;
    logic [77:0] exp_ob;
    iv[k] = v; ib[k] = b; ordy[k] = r;
    len = mq.size();
    if (reset) begin
      exp_ir = 1'b1;
      exp_ov = 1'b0;
    end else begin
      exp_ir = (len < dep_of(k)) || (k == 2 && r);
      exp_ov = (len > 0) || (k == 3 && v);
    end
    exp_ob = (len > 0) ? mq[0] : b;
    @(negedge clock);
    check("in_ready", 78'(ir[k]), 78'(exp_ir));
    check("out_valid", 78'(ov[k]), 78'(exp_ov));
    check("count", 78'(cnt[k]), reset ? 78'(0) : 78'(len));
    if (exp_ov) check("out_bits", ob[k], exp_ob);
    acc = v && exp_ir && !reset;
    deq = exp_ov && r;
    byp = (k == 3) && (len == 0) && deq;
    @(posedge clock);
    #1;
    if (reset) begin
      mq.delete();
    end else if (!byp) begin
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
  endtask

  // Push n beats with random valid/ready duty cycles, then drain.
  task automatic run(input int k, input int n, input int pv, input int pr);
    int sent;
    int guard;
    logic holding, v, r, acc;
    logic [77:0] cur;
    sent = 0; guard = 0; holding = 1'b0;
    cur = gen(0);
    while ((sent < n || mq.size() != 0) && guard < 3000) begin
      v = (sent < n) && (holding || ($urandom_range(99) < pv));
      r = ($urandom_range(99) < pr);
      step(k, v, cur, r, acc);
      holding = v && !acc;
      if (acc) begin
        sent++;
        cur = gen(sent);
      end
      guard++;
    end
    vectors++;
    if (guard >= 3000) begin
      miscompares++;
      $display("FAIL run_timeout inst=%0d sent=%0d required=%0d", k, sent, n);
    end
  endtask

  initial begin
    logic acc;
    logic [77:0] b1, b2, b3, bx;
    int sent3, guard;
    iv = '0; ordy = '0; ib = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    step(0, 1'b1, gen(99), 1'b0, acc);
    step(0, 1'b0, '0, 1'b0, acc);
    reset = 1'b0;

    // Fill DEPTH2, hold off the third beat, then drain in order.
    b1 = mk_beat(3'd0, 7'h01, 25'h10, 32'h1111, 1'b0);
    b2 = mk_beat(3'd0, 7'h02, 25'h20, 32'h2222, 1'b0);
    b3 = mk_beat(3'd0, 7'h03, 25'h30, 32'h3333, 1'b0);
    step(0, 1'b1, b1, 1'b0, acc);
    step(0, 1'b1, b2, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(0, 1'b1, b3, 1'b0, acc);
    sent3 = 0; guard = 0;
    while ((sent3 == 0 || mq.size() != 0) && guard < 20) begin
      step(0, sent3 == 0, b3, 1'b1, acc);
      if (acc) sent3 = 1;
      guard++;
    end
    step(0, 1'b0, '0, 1'b0, acc);

    // Streaming at full rate, then random stalls, on DEPTH2.
    run(0, 16, 100, 100);
    run(0, 40, 60, 50);

    // DEPTH3 wrap with random stalls.
    run(1, 10, 80, 50);
    run(1, 30, 70, 40);

    // PIPE DEPTH1: full queue is replaced while draining.
    step(2, 1'b1, mk_beat(3'd4, 7'h11, 25'h40, 32'hAAAA0001, 1'b0), 1'b0, acc);
    step(2, 1'b1, mk_beat(3'd4, 7'h12, 25'h44, 32'hAAAA0002, 1'b0), 1'b1, acc);
    step(2, 1'b0, '0, 1'b0, acc);
    step(2, 1'b0, '0, 1'b1, acc);
    run(2, 20, 90, 70);

    // FLOW bypass when empty, storage when consumer stalls.
    bx = mk_beat(3'd1, 7'h21, 25'h80, 32'hDEADBEEF, 1'b0);
    step(3, 1'b1, bx, 1'b1, acc);
    step(3, 1'b0, '0, 1'b0, acc);
    step(3, 1'b1, bx, 1'b0, acc);
    step(3, 1'b0, '0, 1'b0, acc);
    step(3, 1'b0, '0, 1'b1, acc);
    run(3, 30, 60, 60);

    // Reset mid-stream with two held beats; a beat offered during reset is dropped.
    step(0, 1'b1, gen(50), 1'b0, acc);
    step(0, 1'b1, gen(51), 1'b0, acc);
    step(0, 1'b0, '0, 1'b0, acc);
    reset = 1'b1;
    step(0, 1'b1, gen(52), 1'b0, acc);
    reset = 1'b0;
    step(0, 1'b0, '0, 1'b1, acc);
    step(0, 1'b0, '0, 1'b1, acc);
    run(0, 10, 70, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_a_channel_queue.md
Name: tl_a_channel_queue

Overview:
- Registered buffer for a TileLink-style A channel (opcode/param/size/source/address/mask/data/corrupt).
- Sits directly upstream of the A-channel pass-through bundle stage. Decouples producer timing from the consumer and breaks the valid/ready combinational path.
- Circular FIFO with optional pipe (enqueue-on-full-while-dequeuing) and flow (empty bypass) modes.

Parameters:
- DEPTH, 2, number of entries; legal 1..16.
- PIPE, 0, 1 = in_ready also high when full and out_ready is high this cycle.
- FLOW, 0, 1 = when empty, in_valid/in_bits pass combinationally to the output, and nothing is stored if out_ready is high.

Ports:
- clock  input  1  sole clock; all state on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  queue can accept a beat.
- in_bits  input  78  packed beat, MSB to LSB: opcode[77:75], param[74:72], size[71:69], source[68:62], address[61:37], mask[36:33], data[32:1], corrupt[0].
- out_valid  output  1  beat available to consumer.
- out_ready  input  1  consumer accepts.
- out_bits  output  78  head beat, same packing.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 78 register array, enq_ptr, deq_ptr, maybe_full flag. ptr_match = (enq_ptr == deq_ptr).
- empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- do_enq = in_valid & in_ready.
- do_deq = out_valid & out_ready.
- Pointer wrap: each pointer increments by 1 on its fire and wraps from DEPTH-1 to 0. This is not power-of-two masking; DEPTH=3 must work.
- maybe_full updates to do_enq only when do_enq != do_deq; otherwise it holds.
- in_ready = ~full | (PIPE & out_ready).
- out_valid = ~empty | (FLOW & in_valid).
- out_bits = head entry, or in_bits when FLOW and empty.
- FLOW bypass: when FLOW, empty and out_ready, do_enq and do_deq both fire but the array and pointers stay unchanged.
- Latency: 1 cycle from in fire to out_valid (FLOW=0). Throughput: 1 beat/cycle sustained when DEPTH>=2 or PIPE=1.
- Simultaneous enqueue and dequeue while not empty: both pointers advance; count and maybe_full are unchanged.
- DEPTH=1, PIPE=0: alternates, max 1 beat per 2 cycles.
- count:
  - equals (enq_ptr - deq_ptr) mod DEPTH when not full; equals DEPTH when full.
  - Registered-state derived; it does not include a FLOW bypass beat.
- Reset (synchronous, active-high):
  - enq_ptr=0, deq_ptr=0, maybe_full=0.
  - Outputs during and after reset: out_valid=0 (FLOW=0), count=0, in_ready=1.
  - Array contents are not reset; out_bits is don't-care while out_valid=0.
  - Reset mid-stream discards all held beats. A beat offered in the reset cycle is dropped.
- Ordering: strict FIFO; no reordering by source.
- Payload is stored verbatim; no field is interpreted.
- Protocol assertions (simulation only):
  - in_bits stable while in_valid & ~in_ready.
  - out_valid never drops without do_deq (FLOW=0).

Test Plan:
- DEPTH=2, out_ready=0: enqueue beats with source 0x01 and 0x02 -> count=2, in_ready=0 next cycle. Third beat 0x03 is held off. Then raise out_ready -> outputs 0x01, 0x02, 0x03 in order, count returns to 0.
- Back-to-back streaming, DEPTH=2, out_ready=1 constantly, 16 beats with address 0x0000000+4*i -> one beat/cycle, first out 1 cycle after first in, data order preserved, count never exceeds 1.
- Wrap: DEPTH=3, push/pop 10 beats with random out_ready stalls -> pointers wrap 2->0, scoreboard matches all 78 bits (incl. corrupt=1 on beat 7).
- PIPE=1, DEPTH=1: queue full with opcode=4, out_ready=1 and in_valid=1 -> in_ready=1 same cycle, new beat replaces, count stays 1.
- FLOW=1, empty, out_ready=1, in_bits data=0xDEADBEEF -> out_valid=1 and out_bits match in same cycle, count stays 0. With out_ready=0, beat is stored and count=1 next cycle.
- Reset with count=2 mid-stream -> cycle after reset: out_valid=0, count=0, in_ready=1. Old beats never appear at the output.
